// File: rtl/rx_dcoffset_mc.sv
// Multi-channel RX DC offset corrector: one shared two-stage datapath, per channel/rail accumulators.
// Optional macro RX_DCOFFSET_MC_ACC_SAT_EN makes the accumulator add saturate instead of wrapping.
module rx_dcoffset_mc #(
    parameter int          WIDTH         = 16,
    parameter int          NUM_CHAN      = 4,
    parameter logic [7:0]  ADDR_BASE     = 8'd0,
    parameter int          MAX_SHIFT     = 24,
    parameter int          SHIFT_DEFAULT = 20,
    localparam int         CW            = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    set_stb,
    input  logic [7:0]              set_addr,
    input  logic [31:0]             set_data,
    input  logic                    in_stb,
    input  logic [CW-1:0]           in_chan,
    input  logic [WIDTH-1:0]        in_i,
    input  logic [WIDTH-1:0]        in_q,
    output logic                    out_stb,
    output logic [CW-1:0]           out_chan,
    output logic [WIDTH-1:0]        out_i,
    output logic [WIDTH-1:0]        out_q
);
    localparam int         AW         = WIDTH + MAX_SHIFT;
    localparam logic [7:0] GLOBAL_OFF = 8'(2 * NUM_CHAN);

    // Top WIDTH bits of the accumulator, rounded half-up; rounding overflow clips to +max.
    function automatic logic [WIDTH-1:0] corr_of(input logic [AW-1:0] acc);
        logic [AW:0]    rnd;
        logic [WIDTH:0] top;
        rnd = {acc[AW-1], acc} + ((AW+1)'(1) << (MAX_SHIFT - 1));
        top = rnd[AW:MAX_SHIFT];
        if (top[WIDTH] != top[WIDTH-1]) corr_of = {1'b0, {(WIDTH-1){1'b1}}};
        else                             corr_of = top[WIDTH-1:0];
    endfunction

    function automatic logic [WIDTH-1:0] sat_sub(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [WIDTH:0] d;
        d = {a[WIDTH-1], a} - {b[WIDTH-1], b};
        if (d[WIDTH] != d[WIDTH-1]) sat_sub = d[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        else                        sat_sub = d[WIDTH-1:0];
    endfunction

    function automatic logic [AW-1:0] acc_add(input logic [AW-1:0] acc, input logic [WIDTH-1:0] y,
                                              input logic [4:0] sh);
        logic [AW-1:0] inc;
        inc = {{(AW-WIDTH){y[WIDTH-1]}}, y} << (MAX_SHIFT - int'(sh));
`ifdef RX_DCOFFSET_MC_ACC_SAT_EN
        begin
            logic [AW:0] sum;
            sum = {acc[AW-1], acc} + {inc[AW-1], inc};
            if (sum[AW] != sum[AW-1]) acc_add = sum[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
            else                      acc_add = sum[AW-1:0];
        end
`else
        acc_add = acc + inc;
`endif
    endfunction

    logic                s1_vld_r;
    logic [CW-1:0]       s1_chan_r;
    logic [WIDTH-1:0]    s1_i_r, s1_q_r;
    logic                wr_vld_r;
    logic [7:0]          wr_addr_r;
    logic [31:0]         wr_data_r;
    logic [AW-1:0]       acc_i_r [NUM_CHAN];
    logic [AW-1:0]       acc_q_r [NUM_CHAN];
    logic [NUM_CHAN-1:0] fixed_i_r, fixed_q_r;
    logic [4:0]          shift_r;
    logic                freeze_r;

    logic                chan_ok_s;
    logic [CW-1:0]       idx_s;
    logic [WIDTH-1:0]    corr_i_s, corr_q_s, y_i_s, y_q_s;
    logic [AW-1:0]       next_i_s, next_q_s;
    logic [7:0]          wr_off_s;
    logic                wr_rail_s, wr_glob_s;
    logic [CW-1:0]       wr_chan_s;
    logic [4:0]          shift_clamp_s;

    // Stage-2 datapath and settings decode; acc update is folded into this stage, so no forwarding is needed.
    always_comb begin
        chan_ok_s = (int'(s1_chan_r) < NUM_CHAN);
        idx_s     = chan_ok_s ? s1_chan_r : {CW{1'b0}};
        corr_i_s  = chan_ok_s ? corr_of(acc_i_r[idx_s]) : {WIDTH{1'b0}};
        corr_q_s  = chan_ok_s ? corr_of(acc_q_r[idx_s]) : {WIDTH{1'b0}};
        y_i_s     = sat_sub(s1_i_r, corr_i_s);
        y_q_s     = sat_sub(s1_q_r, corr_q_s);
        next_i_s  = acc_add(acc_i_r[idx_s], y_i_s, shift_r);
        next_q_s  = acc_add(acc_q_r[idx_s], y_q_s, shift_r);
        wr_off_s  = wr_addr_r - ADDR_BASE;
        wr_rail_s = wr_vld_r && (wr_off_s < GLOBAL_OFF);
        wr_glob_s = wr_vld_r && (wr_off_s == GLOBAL_OFF);
        wr_chan_s = wr_off_s[CW:1];
        if (wr_data_r[4:0] == 5'd0)                  shift_clamp_s = 5'd1;
        else if (wr_data_r[4:0] > 5'(MAX_SHIFT))     shift_clamp_s = 5'(MAX_SHIFT);
        else                                         shift_clamp_s = wr_data_r[4:0];
    end

    // Input and settings capture stage plus registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld_r  <= 1'b0;
            s1_chan_r <= {CW{1'b0}};
            s1_i_r    <= {WIDTH{1'b0}};
            s1_q_r    <= {WIDTH{1'b0}};
            wr_vld_r  <= 1'b0;
            wr_addr_r <= 8'd0;
            wr_data_r <= 32'd0;
            out_stb   <= 1'b0;
            out_chan  <= {CW{1'b0}};
            out_i     <= {WIDTH{1'b0}};
            out_q     <= {WIDTH{1'b0}};
        end else begin
            s1_vld_r  <= in_stb;
            s1_chan_r <= in_chan;
            s1_i_r    <= in_i;
            s1_q_r    <= in_q;
            wr_vld_r  <= set_stb;
            wr_addr_r <= set_addr;
            wr_data_r <= set_data;
            out_stb   <= s1_vld_r;
            if (s1_vld_r) begin
                out_chan <= s1_chan_r;
                out_i    <= y_i_s;
                out_q    <= y_q_s;
            end
        end
    end

    // Per-rail state: a settings write to a rail overrides a same-cycle accumulator update.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < NUM_CHAN; c++) begin
                acc_i_r[c] <= {AW{1'b0}};
                acc_q_r[c] <= {AW{1'b0}};
            end
            fixed_i_r <= {NUM_CHAN{1'b0}};
            fixed_q_r <= {NUM_CHAN{1'b0}};
            shift_r   <= 5'(SHIFT_DEFAULT);
            freeze_r  <= 1'b0;
        end else begin
            for (int c = 0; c < NUM_CHAN; c++) begin
                if (wr_rail_s && wr_chan_s == CW'(c) && !wr_off_s[0]) begin
                    fixed_i_r[c] <= wr_data_r[31];
                    if (wr_data_r[30]) acc_i_r[c] <= {wr_data_r[29:0], {(AW-30){1'b0}}};
                end else if (s1_vld_r && chan_ok_s && idx_s == CW'(c) && !freeze_r && !fixed_i_r[c]) begin
                    acc_i_r[c] <= next_i_s;
                end
                if (wr_rail_s && wr_chan_s == CW'(c) && wr_off_s[0]) begin
                    fixed_q_r[c] <= wr_data_r[31];
                    if (wr_data_r[30]) acc_q_r[c] <= {wr_data_r[29:0], {(AW-30){1'b0}}};
                end else if (s1_vld_r && chan_ok_s && idx_s == CW'(c) && !freeze_r && !fixed_q_r[c]) begin
                    acc_q_r[c] <= next_q_s;
                end
            end
            if (wr_glob_s) begin
                shift_r  <= shift_clamp_s;
                freeze_r <= wr_data_r[8];
            end
        end
    end
endmodule
